conv1_window_streamer: RTL
==========================

// Module: conv1_window_streamer
// PURPOSE
//  Producer side of the conv1 5x5 window interface. Accepts a 28x28 float8 image one pixel per
//  beat in raster order, buffers K-1 lines, and emits every valid KxK window (24x24 = 576 per frame)
//  as a packed 200-bit word for a single time-shared TPU_Conv_25 + Float8Adder lane.
//  It replaces the fully-parallel flat-tensor feed with a streaming, backpressured one.
// PARAMETERS
//  IMG_W  28  image width in pixels
//  IMG_H  28  image height in pixels
//  K      5   window edge; outputs per frame = (IMG_W-K+1)*(IMG_H-K+1)
//  DW     8   pixel width (float8, passed through untouched)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  pix_valid  in   1         input pixel valid
//  pix_ready  out  1         input pixel accepted when pix_valid & pix_ready
//  pix_data   in   DW        pixel value
//  pix_sof    in   1         qualifies pixel (0,0) of a frame
//  win_valid  out  1         window valid
//  win_ready  in   1         downstream accepts window
//  win_data   out  K*K*DW    window, top-left pixel in MSBs, raster order within window
//  win_last   out  1         marks window (IMG_H-K, IMG_W-K), last of frame
//  frame_err  out  1         one-cycle pulse: pix_sof seen at a position other than (0,0)
// BEHAVIOUR
//  - Reset: win_valid=0, win_last=0, frame_err=0, win_data=0, counters row=col=0, FSM=FILL. Line
//    buffer contents not cleared (never read before rewritten).
//  - pix_ready = !win_valid | win_ready (one output register stage; no combinational ready loop
//    through data).
//  - Counters in_row/in_col advance per accepted pixel; col wraps at IMG_W-1 -> 0 with row+1;
//    row wraps at IMG_H-1 -> 0 (frame end).
//  - win_data[(K*K-1-(r*K+c))*DW +: DW] = pixel(in_row-K+1+r, in_col-K+1+c).
//  - A window is launched on the cycle after accepting pixel (row,col) with row>=K-1 and
//    col>=K-1; latency 1 clk. win_last=1 when that pixel is (IMG_H-1, IMG_W-1).
//  - Output held stable (data, last) while win_valid & !win_ready.
//  - FSM: FILL (row<K-1; no windows) -> STREAM when pixel (K-1,0) accepted -> FILL after
//    pixel (IMG_H-1,IMG_W-1) accepted. Columns 0..K-2 in STREAM produce no window.
//  - pix_sof accepted at (0,0): normal. Accepted elsewhere: frame_err pulses next cycle, that
//    pixel is treated as (0,0), FSM -> FILL; a pending win_valid is still delivered.
//  - Back-to-back frames: no bubble required; pixel (0,0) of frame n+1 may be accepted the
//    cycle after the last pixel of frame n if pix_ready.
//  - Reset mid-frame: all partial state discarded; next window requires a full (K-1)*IMG_W+K
//    pixels.
//  - Window shift register: K rows x K cols; each accepted pixel shifts left by one column,
//    new column = {K-1 line-buffer reads (oldest row first), pix_data}.
// CONFIGURATION
//  CONV1_WIN_COORD_EN defined: adds outputs win_row[4:0], win_col[4:0] (window top-left, held
//    with win_data, reset 0). Undefined: ports absent, no coordinate registers.
// STRUCTURE
//  - conv1_defs.vh: IMG_W/IMG_H/K/DW defaults, WIN_W=K*K*DW, OUT_W=IMG_W-K+1, OUT_H=IMG_H-K+1,
//    FSM state encodings (FILL=1'b0, STREAM=1'b1).
//  - Sub-module conv1_line_buffer: IMG_W x DW circular memory, read-before-write at same address,
//    one instance per buffered line (K-1), chained so line i output feeds line i+1 input.
// TESTING
//  - Stimulus pixel(r,c) = (r*28+c) mod 256, win_ready=1 always, 1 frame -> first win_valid
//    exactly 1 clk after pixel #117 accepted; window(0,0) MSB byte 0x00, LSB byte 0x74.
//  - Same frame -> exactly 576 windows; last has win_last=1, MSB 0x9B, LSB 0x0F; no other
//    win_last.
//  - win_ready=0 for 10 cycles mid-stream -> pix_ready=0 throughout, win_data/win_last stable,
//    no window lost or duplicated.
//  - rst for 1 cycle after 300 pixels -> win_valid=0 next cycle; next window only after 117 new
//    pixels.
//  - pix_sof asserted on pixel #50 -> frame_err=1 for one cycle; that pixel becomes (0,0); first
//    window after 116 more.
//  - Two back-to-back frames, random pix_valid/win_ready (50%) -> 1152 windows, 2 win_last,
//    contents match model; with CONV1_WIN_COORD_EN, coords (0,0)..(23,23) in order.

Source files
------------

// File: rtl/conv1_window_streamer_pkg.sv
// conv1_window_streamer_pkg: image geometry, derived widths and FSM encoding
// shared by the conv1 window streamer, its line buffers and its bus interface.
package conv1_window_streamer_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int DW    = 8;

  localparam int WIN_W = K * K * DW;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // True for the bottom-right pixel, i.e. the last pixel of a frame.
  function automatic logic is_frame_end(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return (r == ROW_LAST) && (c == COL_LAST);
  endfunction

endpackage

// File: rtl/conv1_window_streamer_if.sv
// conv1_window_streamer_if: pixel-in / window-out handshake bundle.
// master = the streamer (accepts pixels, produces windows), slave = its environment.
// With CONV1_WIN_COORD_EN defined the bundle also carries the window coordinates.
interface conv1_window_streamer_if;
  import conv1_window_streamer_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic [DW-1:0]    pix_data;
  logic             pix_sof;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic             win_last;
  logic             frame_err;
`ifdef CONV1_WIN_COORD_EN
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  modport master (
    input  pix_valid, pix_data, pix_sof, win_ready,
    output pix_ready, win_valid, win_data, win_last, frame_err, win_row, win_col
  );
  modport slave (
    output pix_valid, pix_data, pix_sof, win_ready,
    input  pix_ready, win_valid, win_data, win_last, frame_err, win_row, win_col
  );
`else
  modport master (
    input  pix_valid, pix_data, pix_sof, win_ready,
    output pix_ready, win_valid, win_data, win_last, frame_err
  );
  modport slave (
    output pix_valid, pix_data, pix_sof, win_ready,
    input  pix_ready, win_valid, win_data, win_last, frame_err
  );
`endif

endinterface

// File: rtl/conv1_window_streamer_line_buffer.sv
// conv1_window_streamer_line_buffer: one image line of pixels in a circular
// memory addressed by column. The read is combinational from the old contents,
// so a write at the same address returns the pixel stored one line earlier.
// Contents are never cleared; every entry is rewritten before it is read back.
module conv1_window_streamer_line_buffer
  import conv1_window_streamer_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout
);

  logic [DW-1:0] mem_q [IMG_W];

  assign dout = mem_q[addr];

  // Store the incoming pixel over the one it displaces.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= din;
  end

endmodule

// File: rtl/conv1_window_streamer.sv
// conv1_window_streamer: takes a 28x28 image one pixel per beat in raster order
// and emits every 5x5 window as a packed word (top-left pixel in the MSBs),
// one output register stage, backpressured by win_ready.
// Build option: define CONV1_WIN_COORD_EN to add win_row/win_col outputs.
//
// state     | meaning
// ST_FILL   | buffering rows 0..K-2 of a frame, no windows launched
// ST_STREAM | rows K-1..IMG_H-1, a window launches for each pixel with col >= K-1
module conv1_window_streamer
  import conv1_window_streamer_pkg::*;
(
  input logic clk,
  input logic rst,
  conv1_window_streamer_if.master bus
);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             frame_err_q, frame_err_d;
  logic [WIN_W-1:0] win_data_q, win_data_d;
`ifdef CONV1_WIN_COORD_EN
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
`endif

  logic [DW-1:0]    win_sh_q [K][K];
  logic [DW-1:0]    win_sh_d [K][K];
  logic [DW-1:0]    lb_din   [K-1];
  logic [DW-1:0]    lb_dout  [K-1];
  logic [WIN_W-1:0] win_next;

  logic             pix_ready;
  logic             accept;
  logic             sof_err;
  logic             launch;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;

  // Ready depends only on registered state and win_ready, never on pixel data.
  assign pix_ready = !win_valid_q || bus.win_ready;
  assign accept    = bus.pix_valid && pix_ready;

  // Position of the pixel on the bus; a start-of-frame always restarts at (0,0).
  always_comb begin
    pos_row = row_q;
    pos_col = col_q;
    sof_err = 1'b0;
    if (bus.pix_sof) begin
      pos_row = '0;
      pos_col = '0;
      sof_err = (row_q != '0) || (col_q != '0);
    end
  end

  // Line buffers chained so line i holds the pixels of row (current - 1 - i).
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_din[i] = bus.pix_data;
    end else begin : g_chain
      assign lb_din[i] = lb_dout[i-1];
    end
    conv1_window_streamer_line_buffer u_lb (
      .clk   (clk),
      .wr_en (accept),
      .addr  (pos_col),
      .din   (lb_din[i]),
      .dout  (lb_dout[i])
    );
  end

  // Shift the window left one column and append {line buffers oldest first, pixel}.
  always_comb begin
    win_sh_d = win_sh_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_sh_d[r][c] = win_sh_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_sh_d[r][K-1] = lb_dout[K-2-r];
      end
      win_sh_d[K-1][K-1] = bus.pix_data;
    end
  end

  // Pack the updated window in raster order, top-left pixel in the MSBs.
  always_comb begin
    win_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_next[(K*K-1-(r*K+c))*DW +: DW] = win_sh_d[r][c];
      end
    end
  end

  // Position counters, FILL/STREAM sequencing and the output register stage.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_data_d  = win_data_q;
    frame_err_d = 1'b0;
    launch      = 1'b0;
`ifdef CONV1_WIN_COORD_EN
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
`endif
    if (win_valid_q && bus.win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    if (accept) begin
      frame_err_d = sof_err;
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      case (state_q)
        ST_FILL: begin
          if (pos_row == ROW_FIRST_WIN && pos_col == '0) state_d = ST_STREAM;
        end
        ST_STREAM: begin
          if (bus.pix_sof) begin
            state_d = ST_FILL;
          end else begin
            launch = (pos_col >= COL_FIRST_WIN);
            if (is_frame_end(pos_row, pos_col)) state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
    if (launch) begin
      win_valid_d = 1'b1;
      win_last_d  = is_frame_end(pos_row, pos_col);
      win_data_d  = win_next;
`ifdef CONV1_WIN_COORD_EN
      win_row_d   = pos_row - ROW_FIRST_WIN;
      win_col_d   = pos_col - COL_FIRST_WIN;
`endif
    end
  end

  // Control and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      win_data_q  <= '0;
`ifdef CONV1_WIN_COORD_EN
      win_row_q   <= '0;
      win_col_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      frame_err_q <= frame_err_d;
      win_data_q  <= win_data_d;
`ifdef CONV1_WIN_COORD_EN
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
`endif
    end
  end

  // Window shift register is pure datapath; stale contents never reach the output.
  always_ff @(posedge clk) begin
    win_sh_q <= win_sh_d;
  end

  assign bus.pix_ready = pix_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.win_data  = win_data_q;
  assign bus.frame_err = frame_err_q;
`ifdef CONV1_WIN_COORD_EN
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
`endif

endmodule
